// File: rtl/muldiv_seq_pkg.sv
// Shared encodings for the iterative multiply/divide sequencer.
package muldiv_seq_pkg;

  localparam int MD_WIDTH = 16;
  localparam int MD_ITERS = 16;

  typedef enum logic [1:0] {
    MD_MUL   = 2'b00,
    MD_MULHU = 2'b01,
    MD_DIVU  = 2'b10,
    MD_REMU  = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_MUL  = 2'b01,
    ST_DIV  = 2'b10,
    ST_DONE = 2'b11
  } md_state_e;

endpackage

// File: rtl/muldiv_seq_if.sv
// Start/busy/done handshake and operand/result bus between pipeline control and the sequencer.
interface muldiv_seq_if #(
  parameter int WIDTH = 16
);
  import muldiv_seq_pkg::*;

  logic             start;
  md_op_e           op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             flush;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] res;
  logic             div_by_zero;

  modport master (
    output start, op, a, b, flush,
    input  busy, done, res, div_by_zero
  );

  modport slave (
    input  start, op, a, b, flush,
    output busy, done, res, div_by_zero
  );

endinterface

// File: rtl/rca_16b.sv
// 16-bit ripple-carry adder; the single adder shared by multiply and divide iterations.
module rca_16b (
  input  logic [15:0] x,
  input  logic [15:0] y,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        cout
);

  always_comb begin : ripple
    logic c;
    c = cin;
    for (int i = 0; i < 16; i++) begin
      sum[i] = x[i] ^ y[i] ^ c;
      c      = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
    end
    cout = c;
  end

endmodule

// File: rtl/muldiv_seq.sv
// Multi-cycle sequencer: shift-add multiply and restoring divide, 16 iterations on one shared adder.
module muldiv_seq
  import muldiv_seq_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input  logic          clk,
  input  logic          rst,
  muldiv_seq_if.slave   bus
);

  md_state_e        state_q, state_d;
  md_op_e           op_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [WIDTH-1:0] acc_q, mq_q, acc_d, mq_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             dbz_q, dbz_d;

  logic             accept, last_iter, b_zero, div_ge;
  logic [WIDTH-1:0] add_x, add_y, add_sum;
  logic             add_cin, add_cout;

  assign last_iter = (cnt_q == CNT_W'(MD_ITERS - 1));
  assign b_zero    = (b_q == '0);

  // NOTE: every variable gets a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (bus.start && !bus.flush) begin
          accept  = 1'b1;
          state_d = bus.op[1] ? ST_DIV : ST_MUL;
        end
      end
      ST_MUL: begin
        if (bus.flush)      state_d = ST_IDLE;
        else if (last_iter) state_d = ST_DONE;
      end
      ST_DIV: begin
        if (bus.flush)                state_d = ST_IDLE;
        else if (b_zero || last_iter) state_d = ST_DONE;
      end
    endcase
  end

  // Divide computes {r, q[msb]} - b as add with ~b and carry-in 1; multiply adds a or 0.
  always_comb begin
    add_x   = acc_q;
    add_y   = '0;
    add_cin = 1'b0;
    if (state_q == ST_DIV) begin
      add_x   = {acc_q[WIDTH-2:0], mq_q[WIDTH-1]};
      add_y   = ~b_q;
      add_cin = 1'b1;
    end else if (mq_q[0]) begin
      add_y   = a_q;
    end
  end

  rca_16b u_add (
    .x    (add_x),
    .y    (add_y),
    .cin  (add_cin),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // A set r msb means the shifted partial remainder exceeds 16 bits, so the trial subtract cannot go negative.
  assign div_ge = acc_q[WIDTH-1] | add_cout;

  always_comb begin
    acc_d = acc_q;
    mq_d  = mq_q;
    if (state_q == ST_MUL) begin
      acc_d = {add_cout, add_sum[WIDTH-1:1]};
      mq_d  = {add_sum[0], mq_q[WIDTH-1:1]};
    end else if (state_q == ST_DIV) begin
      if (div_ge) begin
        acc_d = add_sum;
        mq_d  = {mq_q[WIDTH-2:0], 1'b1};
      end else begin
        acc_d = {acc_q[WIDTH-2:0], mq_q[WIDTH-1]};
        mq_d  = {mq_q[WIDTH-2:0], 1'b0};
      end
    end
  end

  always_comb begin
    res_d = res_q;
    dbz_d = 1'b0;
    unique case (op_q)
      MD_MUL, MD_DIVU:  res_d = mq_d;
      MD_MULHU, MD_REMU: res_d = acc_d;
    endcase
    if (state_q == ST_DIV && b_zero) begin
      dbz_d = 1'b1;
      res_d = (op_q == MD_REMU) ? a_q : '1;
    end
  end

  // NOTE: non-blocking assignments, so every register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: the datapath registers are reset too, so res and div_by_zero are defined before the first operation.
      state_q <= ST_IDLE;
      op_q    <= MD_MUL;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      mq_q    <= '0;
      res_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        a_q   <= bus.a;
        b_q   <= bus.b;
        op_q  <= bus.op;
        acc_q <= '0;
        mq_q  <= bus.op[1] ? bus.a : bus.b;
        cnt_q <= '0;
      end else if (state_q == ST_MUL || state_q == ST_DIV) begin
        acc_q <= acc_d;
        mq_q  <= mq_d;
        cnt_q <= cnt_q + CNT_W'(1);
      end
      if (state_d == ST_DONE) begin
        res_q <= res_d;
        dbz_q <= dbz_d;
      end
    end
  end

  assign bus.busy        = (state_q == ST_MUL) || (state_q == ST_DIV);
  assign bus.done        = (state_q == ST_DONE);
  assign bus.res         = res_q;
  assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed scoreboard bench for muldiv_seq: results, latency, busy window, flush and reset aborts.
module tb_muldiv_seq;
  import muldiv_seq_pkg::*;

  typedef struct {
    logic [15:0] res;
    logic        dbz;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  muldiv_seq_if #(.WIDTH(16)) bus ();

  muldiv_seq #(.WIDTH(16), .CNT_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   t_issue  = 0;
  int   done_cnt;
  exp_t sb[$];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] model_res(md_op_e op, logic [15:0] a, logic [15:0] b);
    logic [31:0] p;
    p = {16'h0, a} * {16'h0, b};
    case (op)
      MD_MUL:   return p[15:0];
      MD_MULHU: return p[31:16];
      MD_DIVU:  return (b == 16'h0) ? 16'hFFFF : a / b;
      default:  return (b == 16'h0) ? a : a % b;
    endcase
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Drives a one-cycle start from a negedge; returns at the following negedge.
  task automatic issue(md_op_e op, logic [15:0] a, logic [15:0] b, bit expect_done);
    exp_t e;
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    if (expect_done) begin
      e.res = model_res(op, a, b);
      e.dbz = op[1] && (b == 16'h0);
      sb.push_back(e);
    end
    t_issue = cyc;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Waits (bounded) for done, then checks latency, busy window and the scoreboard entry.
  task automatic wait_done(string tag, int exp_lat, int exp_busy);
    int   n      = 0;
    int   busy_n = 0;
    exp_t e;
    while (bus.done !== 1'b1 && n < 40) begin
      if (bus.busy === 1'b1) busy_n++;
      @(negedge clk);
      n++;
    end
    check({tag, "_done_seen"}, 32'(bus.done), 32'd1);
    check({tag, "_latency"}, 32'(cyc - t_issue), 32'(exp_lat));
    check({tag, "_busy_cycles"}, 32'(busy_n), 32'(exp_busy));
    check({tag, "_busy_in_done"}, 32'(bus.busy), 32'd0);
    check({tag, "_sb_pending"}, 32'(sb.size() != 0), 32'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check({tag, "_res"}, 32'(bus.res), 32'(e.res));
      check({tag, "_dbz"}, 32'(bus.div_by_zero), 32'(e.dbz));
    end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.op    = MD_MUL;
    bus.a     = 16'h0;
    bus.b     = 16'h0;
    bus.flush = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_res", 32'(bus.res), 32'h0);
    check("rst_dbz", 32'(bus.div_by_zero), 32'd0);
    rst = 1'b1;
    @(negedge clk);

    issue(MD_MUL, 16'd3, 16'd5, 1'b1);
    wait_done("mul_3x5", 17, 16);
    @(negedge clk);
    check("mul_done_pulse", 32'(bus.done), 32'd0);
    check("mul_res_hold", 32'(bus.res), 32'h000F);

    issue(MD_MUL, 16'hFFFF, 16'hFFFF, 1'b1);
    wait_done("mul_ffff", 17, 16);
    @(negedge clk);
    issue(MD_MULHU, 16'hFFFF, 16'hFFFF, 1'b1);
    wait_done("mulhu_ffff", 17, 16);
    @(negedge clk);
    issue(MD_DIVU, 16'd100, 16'd7, 1'b1);
    wait_done("divu_100_7", 17, 16);
    @(negedge clk);
    issue(MD_REMU, 16'd100, 16'd7, 1'b1);
    wait_done("remu_100_7", 17, 16);
    @(negedge clk);
    issue(MD_DIVU, 16'h8000, 16'h0001, 1'b1);
    wait_done("divu_8000_1", 17, 16);
    @(negedge clk);

    issue(MD_DIVU, 16'h1234, 16'h0000, 1'b1);
    wait_done("divu_by_zero", 2, 1);
    @(negedge clk);
    issue(MD_REMU, 16'h1234, 16'h0000, 1'b1);
    wait_done("remu_by_zero", 2, 1);
    @(negedge clk);

    // start at iteration 5 must be ignored and leave the captured operands alone
    issue(MD_DIVU, 16'd1000, 16'd3, 1'b1);
    repeat (4) @(negedge clk);
    bus.start = 1'b1;
    bus.op    = MD_MUL;
    bus.a     = 16'd9;
    bus.b     = 16'd9;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done("start_ignored", 17, 11);
    @(negedge clk);

    // flush at iteration 8 aborts without done and keeps the previous result
    issue(MD_MUL, 16'd7, 16'd7, 1'b0);
    repeat (7) @(negedge clk);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    check("flush_busy", 32'(bus.busy), 32'd0);
    check("flush_done", 32'(bus.done), 32'd0);
    check("flush_res_kept", 32'(bus.res), 32'd333);
    done_cnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.done === 1'b1) done_cnt++;
    end
    check("flush_no_late_done", 32'(done_cnt), 32'd0);

    // flush together with start in IDLE drops the start
    bus.start = 1'b1;
    bus.flush = 1'b1;
    bus.op    = MD_MUL;
    bus.a     = 16'd1;
    bus.b     = 16'd1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.flush = 1'b0;
    check("idle_flush_start_busy", 32'(bus.busy), 32'd0);
    @(negedge clk);

    // back-to-back: start in the DONE cycle, second done 17 cycles after the first
    issue(MD_MUL, 16'd3, 16'd5, 1'b1);
    wait_done("b2b_first", 17, 16);
    issue(MD_DIVU, 16'd100, 16'd7, 1'b1);
    wait_done("b2b_second", 17, 16);

    // flush in DONE: done completes, the concurrent start is dropped
    bus.start = 1'b1;
    bus.flush = 1'b1;
    bus.op    = MD_MUL;
    bus.a     = 16'd5;
    bus.b     = 16'd5;
    @(negedge clk);
    bus.start = 1'b0;
    bus.flush = 1'b0;
    check("done_flush_busy", 32'(bus.busy), 32'd0);
    check("done_flush_done", 32'(bus.done), 32'd0);
    check("done_flush_res", 32'(bus.res), 32'h000E);
    @(negedge clk);

    // reset at iteration 10 returns to reset values at once
    issue(MD_MUL, 16'h1234, 16'h0055, 1'b0);
    repeat (9) @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_busy", 32'(bus.busy), 32'd0);
    check("midrst_done", 32'(bus.done), 32'd0);
    check("midrst_res", 32'(bus.res), 32'h0);
    check("midrst_dbz", 32'(bus.div_by_zero), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    issue(MD_MUL, 16'd2, 16'd2, 1'b1);
    wait_done("mul_after_rst", 17, 16);

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
